// File: rtl/sram_controller.sv
// MEM-stage data-memory responder: one 32-bit access served as two 16-bit async SRAM cycles.
// Optional WRITE_POSTED_EN: writes complete to the pipeline at once and drain in the background.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic is_wr;
  logic [SRAM_AW-2:0] word;
  logic [31:0] wdata;
  logic [31:0] offset;
  logic req, req_wr, last;
  logic unused_bits;

  assign offset = address - BASE_ADDR;
  assign req    = rd_en | wr_en;
  assign req_wr = wr_en;
  assign last   = (cnt == LAST);
  assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ready       = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'h0000;
    unique case (state)
      IDLE: begin
        ready = ~req;
`ifdef WRITE_POSTED_EN
        if (req_wr)
          ready = 1'b1;
`endif
        if (req) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end
      end
      LOW, HIGH: begin
        if (is_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state == HIGH) ? wdata[31:16] : wdata[15:0];
          // release we_n on the final cycle so address/data hold past the strobe
          sram_we_n   = last;
        end else begin
          sram_oe_n = 1'b0;
        end
        cnt_nx = cnt + CW'(1);
        if (last) begin
          cnt_nx = '0;
          if (state == LOW)
            state_nx = HIGH;
          else
`ifdef WRITE_POSTED_EN
            state_nx = is_wr ? IDLE : DONE;
`else
            state_nx = DONE;
`endif
        end
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      sram_addr <= '0;
      is_wr     <= 1'b0;
      word      <= '0;
      wdata     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req) begin
        is_wr     <= req_wr;
        word      <= offset[SRAM_AW:2];
        wdata     <= write_data;
        sram_addr <= {offset[SRAM_AW:2], 1'b0};
      end
      if (state == LOW && last)
        sram_addr <= {word, 1'b1};
      if (!is_wr && last) begin
        if (state == LOW)
          read_data[15:0] <= sram_dq_in;
        if (state == HIGH)
          read_data[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM model, directed vector table, reset/posted sequences, random ops.
module tb_sram_controller;

  localparam int W    = 4;
  localparam int BASE = 1024;
  localparam int LAT  = 2 * W + 1;
`ifdef WRITE_POSTED_EN
  localparam int WR_LAT = 0;
`else
  localparam int WR_LAT = LAT;
`endif

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;

  sram_controller #(
    .BASE_ADDR(BASE),
    .SRAM_AW(18),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] sram_mem [0:(1<<18)-1];
  assign sram_dq_in = !sram_oe_n ? sram_mem[sram_addr] : 16'h0000;

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe)
      sram_mem[sram_addr] <= sram_dq_out;

  int we_cnt, oe_cnt, dq_cnt;
  logic seen;
  logic [17:0] first_a, last_a;

  always @(negedge clk) begin
    if (!sram_we_n) we_cnt++;
    if (!sram_oe_n) oe_cnt++;
    if (sram_dq_oe) dq_cnt++;
    if (!sram_oe_n || sram_dq_oe) begin
      if (!seen) first_a = sram_addr;
      last_a = sram_addr;
      seen = 1'b1;
    end
  end

  int checks, failures;
  logic [31:0] model [int];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, output int lat);
    @(posedge clk);
    #1;
    wr_en = wr;
    rd_en = rd;
    address = a;
    write_data = d;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic [17:0] lo);
    int lat;
    we_cnt = 0;
    oe_cnt = 0;
    dq_cnt = 0;
    seen = 1'b0;
    run_req(wr, rd, a, d, lat);
    idle(2 * W + 2);
    chk({tag, " latency"}, 32'(lat), 32'(wr ? WR_LAT : LAT));
    chk({tag, " lo_addr"}, 32'(first_a), 32'(lo));
    chk({tag, " hi_addr"}, 32'(last_a), 32'(lo + 18'd1));
    if (wr) begin
      chk({tag, " we_low"}, 32'(we_cnt), 32'(2 * (W - 1)));
      chk({tag, " dq_oe"}, 32'(dq_cnt), 32'(2 * W));
      chk({tag, " oe_low"}, 32'(oe_cnt), 32'd0);
      chk({tag, " mem_lo"}, 32'(sram_mem[lo]), 32'(d[15:0]));
      chk({tag, " mem_hi"}, 32'(sram_mem[lo + 18'd1]), 32'(d[31:16]));
    end else begin
      chk({tag, " oe_low"}, 32'(oe_cnt), 32'(2 * W));
      chk({tag, " dq_oe"}, 32'(dq_cnt), 32'd0);
      chk({tag, " read_data"}, read_data, exp_rd);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(((a - 32'(BASE)) >> 2) & 32'h1FFFF);
  endfunction

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [17:0] lo;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int lat;
    logic [31:0] a, d, e;
    int w;
    logic op;

    checks = 0;
    failures = 0;
    for (int i = 0; i < (1 << 18); i++) sram_mem[i] = 16'h0000;
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = '0;
    write_data = '0;

    tbl[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, 18'd0};
    tbl[1] = '{1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0};
    tbl[2] = '{1'b1, 1'b0, 32'd1028, 32'h11112222, 32'h0, 18'd2};
    tbl[3] = '{1'b1, 1'b0, 32'd1030, 32'h33334444, 32'h0, 18'd2};
    tbl[4] = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'h33334444, 18'd2};
    tbl[5] = '{1'b1, 1'b0, 32'd1024 + 32'h80000, 32'h55667788, 32'h0, 18'd0};
    tbl[6] = '{1'b0, 1'b1, 32'd1024, 32'h0, 32'h55667788, 18'd0};
    tbl[7] = '{1'b1, 1'b1, 32'd1032, 32'h9ABCDEF0, 32'h0, 18'd4};
    tbl[8] = '{1'b0, 1'b1, 32'd1035, 32'h0, 32'h9ABCDEF0, 18'd4};

    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst we_n", 32'(sram_we_n), 32'd1);
    chk("rst oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst read_data", read_data, 32'd0);
    chk("rst sram_addr", 32'(sram_addr), 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].a,
            tbl[i].d, tbl[i].exp_rd, tbl[i].lo);
      if (tbl[i].wr) model[widx(tbl[i].a)] = tbl[i].d;
    end

    // reset in the middle of a write to a word outside the random range
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    address = 32'(BASE) + 32'h1000;
    write_data = 32'hA5A5A5A5;
    idle(3);
    rst = 1'b1;
    wr_en = 1'b0;
    idle(1);
    @(negedge clk);
    chk("midrst ready", 32'(ready), 32'd1);
    chk("midrst we_n", 32'(sram_we_n), 32'd1);
    chk("midrst dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("midrst oe_n", 32'(sram_oe_n), 32'd1);
    chk("midrst read_data", read_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op("post_rst_rd", 1'b0, 1'b1, 32'd1024, 32'h0, model[0], 18'd0);

`ifdef WRITE_POSTED_EN
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    address = 32'd1024;
    write_data = 32'hCAFEF00D;
    @(negedge clk);
    chk("posted wr ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b1;
    lat = -1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("posted rd latency", 32'(lat), 32'd18);
    chk("posted rd data", read_data, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    model[0] = 32'hCAFEF00D;
    idle(2);
`endif

    for (int i = 0; i < 40; i++) begin
      w = int'($urandom_range(0, 15));
      a = 32'(BASE) + 32'(w * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a + 32'h80000;
      op = 1'($urandom_range(0, 1));
      d = $urandom;
      e = model.exists(w) ? model[w] : 32'h0;
      do_op($sformatf("rnd%0d", i), op, ~op, a, d, e, 18'(w * 2));
      if (op) model[w] = d;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
